// File: rtl/alu_writeback_unit.sv
// ALU write-back unit: buffers ALU result bundles in a small FIFO and
// retires them through one register-file write port plus a HI/LO port.
//
// Handshakes (valid/ready): a bundle transfers on a rising edge where
// res_valid and res_ready are both high; the source holds the bundle
// stable until then. A register write transfers on a rising edge where
// rf_we and rf_ready are both high; while rf_ready is low the pending
// write stays on rf_waddr/rf_wdata unchanged. hi_we/lo_we are one-cycle
// pulses with no back-pressure.
module alu_writeback_unit #(
  parameter int N     = 32,
  parameter int R     = 32,
  parameter int DEPTH = 4,
  localparam int O    = $clog2(R)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         res_valid,
  output logic         res_ready,
  input  logic [O-1:0] GPR_a_idx,
  input  logic [O-1:0] GPR_b_idx,
  input  logic [O-1:0] GPR_c_idx,
  input  logic [N-1:0] GPR_a_dat,
  input  logic [N-1:0] GPR_b_dat,
  input  logic [N-1:0] GPR_c_dat,
  input  logic         GPR_a_val,
  input  logic         GPR_b_val,
  input  logic         GPR_c_val,
  input  logic [N-1:0] SPR_h_dat,
  input  logic [N-1:0] SPR_l_dat,
  input  logic         SPR_h_val,
  input  logic         SPR_l_val,
  input  logic         SPR_o_val,
  input  logic         SPR_z_val,
  output logic         rf_we,
  output logic [O-1:0] rf_waddr,
  output logic [N-1:0] rf_wdata,
  input  logic         rf_ready,
  output logic         hi_we,
  output logic         lo_we,
  output logic [N-1:0] hi_wdata,
  output logic [N-1:0] lo_wdata,
  output logic         ovf_flag,
  output logic         zero_flag,
  output logic         busy,
  output logic         dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  typedef struct packed {
    logic [O-1:0] a_idx;
    logic [O-1:0] b_idx;
    logic [O-1:0] c_idx;
    logic [N-1:0] a_dat;
    logic [N-1:0] b_dat;
    logic [N-1:0] c_dat;
    logic [N-1:0] h_dat;
    logic [N-1:0] l_dat;
    logic         h_val;
    logic         l_val;
    logic         o_val;
    logic         z_val;
  } payload_t;

  // Pending mask {c,b,a} is computed once at push time so r0 writes never
  // reach the issue logic.
  typedef struct packed {
    logic [2:0] pend;
    payload_t   pay;
  } entry_t;

  entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic          state_q, state_d;
  logic [2:0]    mask_q, mask_d;
  logic          first_q, first_d;
  payload_t      cur_q, cur_d;

  entry_t        in_entry, head, nxt;
  logic [AW-1:0] nxt_addr;
  logic          full, empty, any_val, push, pop, issue, done;
  logic [2:0]    sel, mask_after;
  logic [O-1:0]  sel_idx;
  logic [N-1:0]  sel_dat;

  // FIFO status, input packing and the write selection for the entry in service
  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    full      = (count == PW'(DEPTH));
    res_ready = !full && !rst;
    any_val   = GPR_a_val | GPR_b_val | GPR_c_val | SPR_h_val | SPR_l_val
              | SPR_o_val | SPR_z_val;
    push      = res_valid && res_ready && any_val;

    in_entry.pend      = {GPR_c_val && (GPR_c_idx != '0),
                          GPR_b_val && (GPR_b_idx != '0),
                          GPR_a_val && (GPR_a_idx != '0)};
    in_entry.pay.a_idx = GPR_a_idx;
    in_entry.pay.b_idx = GPR_b_idx;
    in_entry.pay.c_idx = GPR_c_idx;
    in_entry.pay.a_dat = GPR_a_dat;
    in_entry.pay.b_dat = GPR_b_dat;
    in_entry.pay.c_dat = GPR_c_dat;
    in_entry.pay.h_dat = SPR_h_dat;
    in_entry.pay.l_dat = SPR_l_dat;
    in_entry.pay.h_val = SPR_h_val;
    in_entry.pay.l_val = SPR_l_val;
    in_entry.pay.o_val = SPR_o_val;
    in_entry.pay.z_val = SPR_z_val;

    nxt_addr = rd_ptr_q[AW-1:0] + AW'(1);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    nxt      = mem_q[nxt_addr];

    issue = (state_q == ST_ISSUE);
    sel   = mask_q[0] ? 3'b001 : mask_q[1] ? 3'b010 : mask_q[2] ? 3'b100 : 3'b000;
    case (sel)
      3'b001:  begin sel_idx = cur_q.a_idx; sel_dat = cur_q.a_dat; end
      3'b010:  begin sel_idx = cur_q.b_idx; sel_dat = cur_q.b_dat; end
      3'b100:  begin sel_idx = cur_q.c_idx; sel_dat = cur_q.c_dat; end
      default: begin sel_idx = '0;          sel_dat = '0;          end
    endcase

    rf_we      = issue && (mask_q != 3'b000) && rf_ready;
    rf_waddr   = issue ? sel_idx : '0;
    rf_wdata   = issue ? sel_dat : '0;
    mask_after = rf_we ? (mask_q & ~sel) : mask_q;
    done       = issue && (mask_after == 3'b000);
    pop        = done;

    hi_we     = issue && first_q && cur_q.h_val;
    lo_we     = issue && first_q && cur_q.l_val;
    hi_wdata  = hi_we ? cur_q.h_dat : '0;
    lo_wdata  = lo_we ? cur_q.l_dat : '0;
    ovf_flag  = cur_q.o_val;
    zero_flag = cur_q.z_val;
    busy      = !empty || issue;
    dbg_state = state_q;
  end

  // Next-state: load head from IDLE, retire one GPR write per ready cycle,
  // and chain straight into the next stored entry when one is finished
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    first_d  = first_q;
    cur_d    = cur_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_ISSUE;
          cur_d   = head.pay;
          mask_d  = head.pend;
          first_d = 1'b1;
        end
      end
      default: begin
        first_d = 1'b0;
        mask_d  = mask_after;
        if (done) begin
          // Only entries already stored count; a same-edge push waits a cycle.
          if (count >= PW'(2)) begin
            cur_d   = nxt.pay;
            mask_d  = nxt.pend;
            first_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            mask_d  = 3'b000;
          end
        end
      end
    endcase
  end

  // Control state; reset abandons any entry in service
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= 3'b000;
      first_q  <= 1'b0;
      cur_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      first_q  <= first_d;
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; validity is tracked purely by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
  end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Bench for alu_writeback_unit: directed scenarios plus a randomized phase,
// with a scoreboard of expected register / HI / LO writes.
module tb_alu_writeback_unit;
  localparam int N = 32;
  localparam int R = 32;
  localparam int O = 5;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid, res_ready;
  logic [O-1:0] GPR_a_idx, GPR_b_idx, GPR_c_idx;
  logic [N-1:0] GPR_a_dat, GPR_b_dat, GPR_c_dat;
  logic         GPR_a_val, GPR_b_val, GPR_c_val;
  logic [N-1:0] SPR_h_dat, SPR_l_dat;
  logic         SPR_h_val, SPR_l_val, SPR_o_val, SPR_z_val;
  logic         rf_we, rf_ready;
  logic [O-1:0] rf_waddr;
  logic [N-1:0] rf_wdata;
  logic         hi_we, lo_we;
  logic [N-1:0] hi_wdata, lo_wdata;
  logic         ovf_flag, zero_flag, busy, dbg_state;

  alu_writeback_unit #(.N(N), .R(R), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .GPR_a_idx(GPR_a_idx), .GPR_b_idx(GPR_b_idx), .GPR_c_idx(GPR_c_idx),
    .GPR_a_dat(GPR_a_dat), .GPR_b_dat(GPR_b_dat), .GPR_c_dat(GPR_c_dat),
    .GPR_a_val(GPR_a_val), .GPR_b_val(GPR_b_val), .GPR_c_val(GPR_c_val),
    .SPR_h_dat(SPR_h_dat), .SPR_l_dat(SPR_l_dat),
    .SPR_h_val(SPR_h_val), .SPR_l_val(SPR_l_val),
    .SPR_o_val(SPR_o_val), .SPR_z_val(SPR_z_val),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .ovf_flag(ovf_flag), .zero_flag(zero_flag), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic [O-1:0] ai, bi, ci;
    logic [N-1:0] ad, bd, cd, hd, ld;
    logic         av, bv, cv, hv, lv, ov, zv;
  } bundle_t;

  // ---------------- scoreboard state ----------------
  logic [O+N-1:0] exp_q[$];
  logic [N-1:0]   hi_q[$];
  logic [N-1:0]   lo_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted bundle yields its GPR writes in a,b,c
  // order (r0 dropped) and its HI/LO writes.
  task automatic model_accept(input bundle_t b);
    if (b.av && b.ai != 0) exp_q.push_back({b.ai, b.ad});
    if (b.bv && b.bi != 0) exp_q.push_back({b.bi, b.bd});
    if (b.cv && b.ci != 0) exp_q.push_back({b.ci, b.cd});
    if (b.hv) hi_q.push_back(b.hd);
    if (b.lv) lo_q.push_back(b.ld);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) begin
        check("rf_we_needs_ready", rf_ready, 1'b1);
        if (exp_q.size() == 0) check("rf_write_unexpected", {rf_waddr, rf_wdata}, '0);
        else check("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
      end
      if (hi_we) begin
        if (hi_q.size() == 0) check("hi_write_unexpected", hi_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("hi_write", hi_wdata, hi_q.pop_front());
      end
      if (lo_we) begin
        if (lo_q.size() == 0) check("lo_write_unexpected", lo_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("lo_write", lo_wdata, lo_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_bundle(input bundle_t b);
    GPR_a_idx = b.ai; GPR_b_idx = b.bi; GPR_c_idx = b.ci;
    GPR_a_dat = b.ad; GPR_b_dat = b.bd; GPR_c_dat = b.cd;
    GPR_a_val = b.av; GPR_b_val = b.bv; GPR_c_val = b.cv;
    SPR_h_dat = b.hd; SPR_l_dat = b.ld;
    SPR_h_val = b.hv; SPR_l_val = b.lv; SPR_o_val = b.ov; SPR_z_val = b.zv;
  endtask

  // Offers a bundle until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input bundle_t b);
    bit ok;
    ok = 0;
    drive_bundle(b);
    res_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      @(posedge clk);
      if (res_ready) begin
        model_accept(b);
        ok = 1;
        break;
      end
    end
    #1 res_valid = 1'b0;
    if (!ok) check("send_timeout", 1'b0, 1'b1);
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.ai = O'($urandom_range(0, 31)); b.bi = O'($urandom_range(0, 31));
    b.ci = O'($urandom_range(0, 31));
    b.ad = $urandom; b.bd = $urandom; b.cd = $urandom; b.hd = $urandom; b.ld = $urandom;
    b.av = 1'($urandom_range(0, 1)); b.bv = 1'($urandom_range(0, 1));
    b.cv = 1'($urandom_range(0, 1)); b.hv = 1'($urandom_range(0, 1));
    b.lv = 1'($urandom_range(0, 1)); b.ov = 1'($urandom_range(0, 1));
    b.zv = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic bundle_t gpr3();
    bundle_t b;
    b = '0;
    b.ai = O'($urandom_range(1, 31)); b.bi = O'($urandom_range(1, 31));
    b.ci = O'($urandom_range(1, 31));
    b.ad = $urandom; b.bd = $urandom; b.cd = $urandom;
    b.av = 1'b1; b.bv = 1'b1; b.cv = 1'b1;
    return b;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rf_we"}, rf_we, 1'b0);
    check({tag, "_hi_lo_we"}, {hi_we, lo_we}, 2'b00);
    check({tag, "_addr_data"}, {rf_waddr, rf_wdata}, '0);
    check({tag, "_hi_lo_data"}, {hi_wdata, lo_wdata}, '0);
    check({tag, "_flags"}, {ovf_flag, zero_flag}, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_state"}, dbg_state, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bundle_t b;
    int run;
    bit rand_done;
    rst = 1'b1; res_valid = 1'b0; rf_ready = 1'b1;
    drive_bundle('0);

    // Reset state
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_res_ready", res_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
    check("after_reset_res_ready", res_ready, 1'b1);
    @(posedge clk); #1;

    // Two GPR writes: latency and back-to-back issue
    b = '0;
    b.ai = 5'd5; b.ad = 32'h1234_5678; b.av = 1'b1;
    b.bi = 5'd7; b.bd = 32'hDEAD_BEEF; b.bv = 1'b1;
    send(b);
    @(negedge clk); check("lat_no_early_we", rf_we, 1'b0);
    @(negedge clk); check("lat_first_we", {rf_we, rf_waddr}, {1'b1, 5'd5});
    check("lat_state_issue", dbg_state, 1'b1);
    @(negedge clk); check("second_we", {rf_we, rf_waddr}, {1'b1, 5'd7});
    @(negedge clk); check("busy_low_after", busy, 1'b0);

    // HI/LO only, with overflow
    @(posedge clk); #1;
    b = '0;
    b.hd = 32'h0000_0001; b.hv = 1'b1;
    b.ld = 32'hFFFF_FFFE; b.lv = 1'b1; b.ov = 1'b1;
    send(b);
    @(negedge clk); check("spr_no_early_we", {hi_we, lo_we}, 2'b00);
    @(negedge clk);
    check("spr_pulse", {hi_we, lo_we, rf_we}, 3'b110);
    check("spr_flags", {ovf_flag, zero_flag}, 2'b10);
    @(negedge clk);
    check("spr_single_pulse", {hi_we, lo_we}, 2'b00);
    check("spr_flag_held", ovf_flag, 1'b1);
    check("spr_busy_low", busy, 1'b0);

    // r0 dropped, r31 written; then an all-invalid bundle is discarded
    @(posedge clk); #1;
    b = '0;
    b.ai = 5'd0; b.ad = 32'h1111_1111; b.av = 1'b1;
    b.ci = 5'd31; b.cd = 32'hA5A5_A5A5; b.cv = 1'b1;
    send(b);
    repeat (4) @(negedge clk);
    check("r31_only_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    b = rand_bundle();
    {b.av, b.bv, b.cv, b.hv, b.lv, b.ov, b.zv} = '0;
    send(b);
    @(negedge clk); check("discard_busy", busy, 1'b0);
    @(negedge clk); check("discard_busy2", busy, 1'b0);
    check("discard_ready", res_ready, 1'b1);

    // Fill with rf_ready low, then drain without bubbles
    @(posedge clk); #1;
    rf_ready = 1'b0;
    repeat (4) send(gpr3());
    @(negedge clk); check("full_res_ready", res_ready, 1'b0);
    drive_bundle(gpr3());
    res_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); check("full_stays_blocked", res_ready, 1'b0);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    rf_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rf_we) run++;
    end
    check("no_bubble_12_writes", run, 12);
    @(negedge clk); check("drain_busy_low", busy, 1'b0);

    // rf_ready pattern 1,0,0,1 inside an entry
    @(posedge clk); #1;
    b = '0;
    b.ai = 5'd3;  b.ad = $urandom; b.av = 1'b1;
    b.bi = 5'd9;  b.bd = $urandom; b.bv = 1'b1;
    b.ci = 5'd17; b.cd = $urandom; b.cv = 1'b1;
    send(b);
    @(posedge clk); #1 rf_ready = 1'b1;
    @(negedge clk); check("hold_first", {rf_we, rf_waddr}, {1'b1, 5'd3});
    @(posedge clk); #1 rf_ready = 1'b0;
    @(negedge clk); check("hold_1", {rf_we, rf_waddr, rf_wdata}, {1'b0, 5'd9, b.bd});
    @(posedge clk); #1 rf_ready = 1'b0;
    @(negedge clk); check("hold_2", {rf_we, rf_waddr, rf_wdata}, {1'b0, 5'd9, b.bd});
    @(posedge clk); #1 rf_ready = 1'b1;
    @(negedge clk); check("hold_release", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd9, b.bd});
    @(negedge clk); check("hold_last", {rf_we, rf_waddr}, {1'b1, 5'd17});
    @(negedge clk); check("hold_busy_low", busy, 1'b0);

    // Reset in the second issue cycle of a three-write entry
    @(posedge clk); #1;
    send(gpr3());
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete(); hi_q.delete(); lo_q.delete();
    #1;
    check_idle_outputs("mid_rst");
    check("mid_rst_res_ready", res_ready, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_res_ready", res_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("post_rst_no_writes", busy, 1'b0);

    // Randomized traffic with random back-pressure
    @(posedge clk); #1;
    rand_done = 0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(rand_bundle());
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rf_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rf_ready = 1'b1;
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    @(negedge clk);
    check("random_drain_busy", busy, 1'b0);
    check("random_rf_q_empty", exp_q.size(), 0);
    check("random_hi_q_empty", hi_q.size(), 0);
    check("random_lo_q_empty", lo_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
